// File: rtl/xtea_result_writer_if.sv
// rtl/xtea_result_writer_if.sv - control, core-capture and result RAM signals of the XTEA result writer
interface xtea_result_writer_if #(
    parameter int AW     = 8,
    parameter int NBYTES = 8
);
    logic                  base_we;
    logic [AW-1:0]         base_addr;
    logic                  arm;
    logic                  core_ready;
    logic [8*NBYTES-1:0]   data_in;
    logic [AW-1:0]         mem_addr;
    logic [7:0]            mem_din;
    logic                  mem_we;
    logic                  busy;
    logic                  done;
    logic                  overrun;
    logic [AW-1:0]         cur_base;

    modport slave (
        input  base_we, base_addr, arm, core_ready, data_in,
        output mem_addr, mem_din, mem_we, busy, done, overrun, cur_base
    );

    modport master (
        output base_we, base_addr, arm, core_ready, data_in,
        input  mem_addr, mem_din, mem_we, busy, done, overrun, cur_base
    );
endinterface

// File: rtl/xtea_result_writer.sv
// rtl/xtea_result_writer.sv - drains one XTEA result block byte-by-byte into the result RAM
// Captures on a core_ready rising edge after arm; base auto-advances by one block per drain.
module xtea_result_writer #(
    parameter int NBYTES = 8,
    parameter int AW     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    xtea_result_writer_if.slave  wr_if
);
    localparam int DW = 8 * NBYTES;
    localparam int CW = $clog2(NBYTES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          ready_q, ready_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_din_q, mem_din_d;
    logic          mem_we_q, mem_we_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          overrun_q, overrun_d;
    logic          rise;

    // A level already high when armed is stale: only a fresh edge captures.
    assign rise = wr_if.core_ready & ~ready_q;

    always_comb begin
        state_d    = state_q;
        ready_d    = wr_if.core_ready;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_we_d   = 1'b0;
        done_d     = done_q;
        overrun_d  = overrun_q;

        // The block in flight keeps a single base address.
        if (state_q != S_WRITE && wr_if.base_we) begin
            base_d = wr_if.base_addr;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (wr_if.arm) begin
                    state_d   = S_ARMED;
                    done_d    = 1'b0;
                    overrun_d = 1'b0;
                end
            end
            S_ARMED: begin
                if (rise) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = base_q;
                    mem_din_d  = wr_if.data_in[7:0];
                    shreg_d    = wr_if.data_in >> 8;
                    cnt_d      = CW'(1);
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                if (cnt_q != '0) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = base_q + AW'(cnt_q);
                    mem_din_d  = shreg_q[7:0];
                    shreg_d    = shreg_q >> 8;
                    cnt_d      = cnt_q + CW'(1);
                end else begin
                    base_d  = base_q + AW'(NBYTES);
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Setting wins over the clear so a simultaneous collision is never lost.
        if ((state_q == S_WRITE && (rise || wr_if.arm)) ||
            (state_q == S_DONE && rise)) begin
            overrun_d = 1'b1;
        end

        busy_d = (state_d == S_WRITE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            shreg_q    <= '0;
            cnt_q      <= '0;
            base_q     <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_we_q   <= mem_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign wr_if.mem_addr = mem_addr_q;
    assign wr_if.mem_din  = mem_din_q;
    assign wr_if.mem_we   = mem_we_q;
    assign wr_if.busy     = busy_q;
    assign wr_if.done     = done_q;
    assign wr_if.overrun  = overrun_q;
    assign wr_if.cur_base = base_q;
endmodule

// File: tb/tb_xtea_result_writer.sv
// tb/tb_xtea_result_writer.sv - randomized self-checking bench for xtea_result_writer
module tb_xtea_result_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    xtea_result_writer_if #(.AW(8), .NBYTES(8)) ifc ();

    xtea_result_writer #(.NBYTES(8), .AW(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .wr_if (ifc)
    );

    logic [7:0] ram     [256] = '{default: 8'h00};
    logic [7:0] exp_ram [256] = '{default: 8'h00};
    int         we_cnt = 0;
    logic [7:0] exp_base;
    int         checks = 0;
    int         errors = 0;

    // Result RAM: write-first, one byte per cycle.
    always @(posedge clk) begin
        if (ifc.mem_we) begin
            ram[ifc.mem_addr] <= ifc.mem_din;
            we_cnt            <= we_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: byte i of the block lands at base+i modulo the address space.
    task automatic model_block(input logic [7:0] base, input logic [63:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            exp_ram[8'(base + i)] = data[8*i +: 8];
        end
    endtask

    task automatic compare_ram(input string tag);
        for (int a = 0; a < 256; a++) begin
            check($sformatf("%s_ram[%0h]", tag, a), ram[a], exp_ram[a]);
        end
    endtask

    task automatic load_base(input logic [7:0] b);
        ifc.base_we   = 1'b1;
        ifc.base_addr = b;
        tick();
        ifc.base_we   = 1'b0;
        exp_base      = b;
        check("cur_base_load", ifc.cur_base, b);
    endtask

    task automatic do_arm(input bit with_base, input logic [7:0] b);
        ifc.arm = 1'b1;
        if (with_base) begin
            ifc.base_we   = 1'b1;
            ifc.base_addr = b;
            exp_base      = b;
        end
        tick();
        ifc.arm     = 1'b0;
        ifc.base_we = 1'b0;
        check("done_clr_on_arm", ifc.done, 1'b0);
        check("overrun_clr_on_arm", ifc.overrun, 1'b0);
        check("cur_base_at_arm", ifc.cur_base, exp_base);
    endtask

    // Raise core_ready and follow the 8-byte drain cycle by cycle.
    task automatic fire(input logic [63:0] data, input bit glitch);
        logic [7:0] b;
        int         w0;
        b  = exp_base;
        w0 = we_cnt;
        ifc.data_in    = data;
        ifc.core_ready = 1'b1;
        tick();
        ifc.data_in = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) begin
            check($sformatf("we_b%0d", i), ifc.mem_we, 1'b1);
            check($sformatf("busy_b%0d", i), ifc.busy, 1'b1);
            check($sformatf("addr_b%0d", i), ifc.mem_addr, 8'(b + i));
            check($sformatf("din_b%0d", i), ifc.mem_din, data[8*i +: 8]);
            if (glitch) begin
                if (i == 2) ifc.core_ready = 1'b0;
                if (i == 3) begin
                    ifc.core_ready = 1'b1;
                    ifc.base_we    = 1'b1;
                    ifc.base_addr  = 8'h80;
                end
                if (i == 4) ifc.base_we = 1'b0;
            end
            tick();
        end
        check("we_after_block", ifc.mem_we, 1'b0);
        check("busy_after_block", ifc.busy, 1'b0);
        check("done_after_block", ifc.done, 1'b1);
        check("cur_base_advance", ifc.cur_base, 8'(b + 8));
        model_block(b, data, 8);
        exp_base       = 8'(b + 8);
        ifc.core_ready = 1'b0;
        tick();
        check("we_count_block", 64'(we_cnt - w0), 64'd8);
    endtask

    initial begin
        logic [63:0] d;
        int          w0;
        logic [7:0]  b;

        ifc.base_we    = 1'b0;
        ifc.base_addr  = '0;
        ifc.arm        = 1'b0;
        ifc.core_ready = 1'b0;
        ifc.data_in    = '0;
        exp_base       = '0;
        tick();
        tick();
        check("rst_mem_addr", ifc.mem_addr, 8'h00);
        check("rst_mem_din", ifc.mem_din, 8'h00);
        check("rst_mem_we", ifc.mem_we, 1'b0);
        check("rst_busy", ifc.busy, 1'b0);
        check("rst_done", ifc.done, 1'b0);
        check("rst_overrun", ifc.overrun, 1'b0);
        check("rst_cur_base", ifc.cur_base, 8'h00);
        rst = 1'b0;
        tick();

        load_base(8'h10);
        do_arm(1'b0, 8'h00);
        fire(64'h8877665544332211, 1'b0);
        check("basic_cur_base", ifc.cur_base, 8'h18);
        compare_ram("basic");

        ifc.core_ready = 1'b1;
        tick();
        tick();
        do_arm(1'b0, 8'h00);
        w0 = we_cnt;
        repeat (20) tick();
        check("stale_no_write", 64'(we_cnt - w0), 64'd0);
        check("stale_busy", ifc.busy, 1'b0);
        check("stale_done", ifc.done, 1'b0);
        ifc.core_ready = 1'b0;
        tick();
        fire({$urandom, $urandom}, 1'b0);
        compare_ram("stale");

        load_base(8'hFC);
        do_arm(1'b0, 8'h00);
        fire(64'h0807060504030201, 1'b0);
        check("wrap_cur_base", ifc.cur_base, 8'h04);
        compare_ram("wrap");

        load_base(8'h30);
        do_arm(1'b0, 8'h00);
        fire({$urandom, $urandom}, 1'b1);
        check("overrun_set", ifc.overrun, 1'b1);
        check("overrun_base_kept", ifc.cur_base, 8'h38);
        compare_ram("overrun");
        do_arm(1'b0, 8'h00);
        fire({$urandom, $urandom}, 1'b0);
        compare_ram("after_overrun");

        load_base(8'h40);
        do_arm(1'b0, 8'h00);
        d  = {$urandom, $urandom};
        w0 = we_cnt;
        ifc.data_in    = d;
        ifc.core_ready = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rstmid_we", ifc.mem_we, 1'b0);
        check("rstmid_cur_base", ifc.cur_base, 8'h00);
        check("rstmid_busy", ifc.busy, 1'b0);
        check("rstmid_done", ifc.done, 1'b0);
        check("rstmid_addr", ifc.mem_addr, 8'h00);
        check("rstmid_din", ifc.mem_din, 8'h00);
        rst            = 1'b0;
        ifc.core_ready = 1'b0;
        tick();
        tick();
        check("rstmid_we_count", 64'(we_cnt - w0), 64'd3);
        model_block(8'h40, d, 3);
        exp_base = 8'h00;
        compare_ram("rstmid");

        load_base(8'h00);
        do_arm(1'b0, 8'h00);
        fire({$urandom, $urandom}, 1'b0);
        do_arm(1'b0, 8'h00);
        fire({$urandom, $urandom}, 1'b0);
        check("b2b_cur_base", ifc.cur_base, 8'h10);
        compare_ram("b2b");

        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            if (k[0]) begin
                load_base(b);
                do_arm(1'b0, 8'h00);
            end else begin
                do_arm(1'b1, b);
            end
            fire({$urandom, $urandom}, 1'b0);
        end
        compare_ram("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/xtea_result_writer.md
# xtea_result_writer

Autonomous result-drain stage downstream of the XTEA core. Once armed, it waits for the core's `ready` to rise, captures the 64-bit result, and writes it byte-by-byte into the result RAM (Mem3). Writes start at a programmable base address, which then auto-advances by 8 so consecutive blocks pack contiguously. It replaces the per-byte software loop of port 0x35 reads and 0x40/0x41 writes; the Pico only programs the base, arms, and polls `done`.

## Interface

Parameters:
- `NBYTES`, default 8: bytes per result block. Fixed at 8 for XTEA; the width of `data_in` is `8*NBYTES`.
- `AW`, default 8: width of the result RAM address.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `base_we`  in  1  load `base_addr` into the internal base register.
- `base_addr`  in  AW  new base address.
- `arm`  in  1  single-cycle pulse: wait for the next result.
- `core_ready`  in  1  XTEA core ready/done level.
- `data_in`  in  64  XTEA `data_out`.
- `mem_addr`  out  AW  result RAM address (registered).
- `mem_din`  out  8  result RAM write data (registered).
- `mem_we`  out  1  result RAM write enable (registered).
- `busy`  out  1  high while in WRITE.
- `done`  out  1  sticky; block fully written.
- `overrun`  out  1  sticky error flag.
- `cur_base`  out  AW  current base register value.

## Operation

- States:
  - IDLE: reset state.
  - ARMED: waiting for a result.
  - WRITE: draining bytes to RAM.
  - DONE: block written.
- Internal registers:
  - `ready_q`: previous-cycle `core_ready`.
  - `shreg[63:0]`: captured result.
  - `cnt[2:0]`: byte counter.
  - `base_r[AW-1:0]`: base address.
- IDLE or DONE, `arm`=1: go to ARMED and clear `done`. `arm` is ignored in ARMED.
- ARMED, rising edge of `core_ready` (`core_ready`=1 and `ready_q`=0):
  - `mem_we`<=1, `mem_addr`<=`base_r`, `mem_din`<=`data_in[7:0]`.
  - `shreg`<=`data_in`>>8, `cnt`<=1, go to WRITE.
  - A level that is already high when armed is stale and does not trigger a capture.
- WRITE, `cnt`≠0: `mem_we`<=1, `mem_addr`<=`base_r`+`cnt` (mod 2^AW), `mem_din`<=`shreg[7:0]`, `shreg`>>=8, `cnt`++.
- WRITE, `cnt` wrapped to 0 (8th byte issued):
  - `mem_we`<=0, `base_r`<=`base_r`+8 (mod 2^AW).
  - `done`<=1, go to DONE.
- Byte order is little-endian: byte i = `data_in[8i+7:8i]` goes to address base+i. This is the same order as the 0x35 result pointer.
- Address arithmetic is AW-bit and wraps silently past 2^AW−1.
- `base_we`: updates `base_r` in IDLE, ARMED and DONE. It is ignored in WRITE, so the block in flight always uses one base.
- `base_we` and `arm` in the same cycle: both take effect. The new base is used for the next block.
- Rising `core_ready` while in WRITE or DONE, or `arm` while in WRITE:
  - Sets `overrun`=1.
  - The in-flight write continues unaltered.
  - `overrun` is cleared only by the next `arm` accepted from IDLE or DONE, or by `rst`.
- `busy` = (state==WRITE), registered.
- `cur_base` = `base_r`.

## Timing

- Reset values:
  - `mem_addr`=0, `mem_din`=0, `mem_we`=0, `busy`=0, `done`=0, `overrun`=0, `cur_base`=0.
  - State IDLE, `ready_q`=0, `shreg`=0, `cnt`=0.
- Let edge E be the edge that samples the `core_ready` rise in ARMED.
  - `mem_we` is high for exactly 8 consecutive cycles, after edges E..E+7.
  - `busy` is high for the same 8 cycles.
  - `done`=1 and `busy`=0 after edge E+8.
  - `cur_base` advances after edge E+8.
- `arm` sampled at edge A: state is ARMED after edge A. The earliest valid capture edge is A+1, provided `ready_q` was 0 at A.
- `rst` asserted mid-WRITE: after that edge, `mem_we`=0 and all outputs are at reset values. No further bytes are written; bytes already written remain in RAM.
- One byte per cycle, no stalls. The result RAM is assumed single-port, write-first, and able to accept a write every cycle.

## Test plan

- **Basic write.** `base_we` with 0x10, `arm`, then `core_ready` 0→1 with `data_in`=64'h8877665544332211.
  - RAM[0x10..0x17] = 11 22 33 44 55 66 77 88.
  - `mem_we` high for 8 cycles.
  - `done`=1 at E+8; `cur_base`=0x18.
- **Stale ready.** Hold `core_ready`=1, then `arm`.
  - No write for 20 cycles.
  - Drop `core_ready` to 0 for 1 cycle, then raise it: 8 writes occur.
- **Address wrap.** Base 0xFC, `data_in`=64'h0807060504030201.
  - Addresses FC FD FE FF 00 01 02 03 receive 01..08.
  - `cur_base`=0x04.
- **Overrun and base_we during WRITE.** Raise `core_ready` again during WRITE, and assert `base_we` with 0x80 in the same window.
  - `overrun`=1.
  - Writes of the first block are unchanged.
  - `cur_base` = old base + 8, not 0x80.
  - The next `arm` clears `overrun`.
- **Reset mid-write.** Assert `rst` after the 3rd write.
  - `mem_we`=0 and `cur_base`=0 next cycle.
  - Only 3 bytes are written.
- **Back-to-back blocks.** `arm` at DONE with base 0x00, sending two blocks.
  - Bytes land at 0x00–0x07 and 0x08–0x0F.
  - `done` is cleared on the second `arm` and set again at its E+8.
